// File: rtl/equiv_check_pkg.sv
// Shared types and helpers for the equivalence-check sequencer.
// Contents: state_t FSM encoding, LFSR polynomial, counter width,
//           walking-ones successor and Galois LFSR step functions.
package equiv_check_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        RAND = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
    localparam int          CNT_W     = 16;

    // Walking-ones ramp successor: shift left and fill with a one.
    // Works on a 32-bit container so any WIDTH in 1..32 can slice the result.
    function automatic logic [31:0] next_walk(input logic [31:0] stim);
        return {stim[30:0], 1'b1};
    endfunction

    // One step of a right-shifting Galois LFSR.
    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ LFSR_POLY) : (x >> 1);
    endfunction

endpackage

// File: rtl/equiv_lfsr.sv
// 32-bit Galois LFSR (polynomial LFSR_POLY). load has priority over step.
// Ports: clk, rst_n (async active-low), load/seed (reload), step (advance once),
//        q (current state). RESET_VAL is the value taken during reset.
module equiv_lfsr
    import equiv_check_pkg::*;
#(
    parameter logic [31:0] RESET_VAL = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        step,
    output logic [31:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_VAL;
        end else if (load) begin
            q <= seed;
        end else if (step) begin
            q <= lfsr_step(q);
        end
    end

endmodule

// File: rtl/equiv_check_sequencer.sv
// Stimulus sequencer + self-checker for golden vs post-route netlist equivalence runs.
// Sequence: walking-ones ramp (WIDTH+1 vectors) then RAND_COUNT LFSR vectors; each
// vector is held SETTLE cycles before its compare, SETTLE+1 cycles per vector total.
// Ports: clk, rst_n, start (pulse, honoured in IDLE/DONE only), golden_b/netlist_b
//        (DUT outputs), stim (shared stimulus), busy, cmp_valid/mismatch (per compare),
//        mismatch_cnt (saturating), vec_cnt, done, pass.
// Optional macro EQUIV_FAIL_CAPTURE_EN adds first_fail_vec/idx/golden/valid, which
// latch on the first mismatching compare of a run.
module equiv_check_sequencer
    import equiv_check_pkg::*;
#(
    parameter int          WIDTH      = 8,
    parameter int          RAND_COUNT = 3000,
    parameter int          SETTLE     = 1,
    parameter logic [31:0] LFSR_SEED  = 32'h0000_0001
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             golden_b,
    input  logic             netlist_b,
    output logic [WIDTH-1:0] stim,
    output logic             busy,
    output logic             cmp_valid,
    output logic             mismatch,
    output logic [15:0]      mismatch_cnt,
    output logic [15:0]      vec_cnt,
    output logic             done,
`ifdef EQUIV_FAIL_CAPTURE_EN
    output logic [WIDTH-1:0] first_fail_vec,
    output logic [15:0]      first_fail_idx,
    output logic [0:0]       first_fail_golden,
    output logic             first_fail_valid,
`endif
    output logic             pass
);

    // A zero seed would lock the LFSR at zero.
    localparam logic [31:0]      SEED_EFF  = (LFSR_SEED == 32'd0) ? 32'd1 : LFSR_SEED;
    localparam logic [7:0]       SETTLE_C  = 8'(SETTLE);
    localparam bit               HAS_RAND  = (RAND_COUNT != 0);
    localparam logic [CNT_W-1:0] RAND_LAST = HAS_RAND ? CNT_W'(RAND_COUNT - 1) : '0;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] stim_q;
    logic [7:0]       settle_cnt;
    logic [CNT_W-1:0] vec_q;
    logic [CNT_W-1:0] mm_q;
    logic [CNT_W-1:0] rand_cnt;
    logic [31:0]      lfsr_q;
    logic [31:0]      stim_ext;
    logic [31:0]      walk_ext;
    logic [31:0]      lfsr_adv;
    logic             running;
    logic             start_acc;
    logic             cmp;
    logic             differ;
    logic             walk_last;
    logic             rand_last;
    logic             lfsr_step_en;
    logic             unused_bits;

    assign running   = (state == WALK) || (state == RAND);
    assign start_acc = start && !running;
    assign cmp       = running && (settle_cnt == SETTLE_C);
    // 4-state compare: X/Z on either side is a mismatch in simulation.
    assign differ    = (golden_b !== netlist_b);

    always_comb begin
        stim_ext              = '0;
        stim_ext[WIDTH-1:0]   = stim_q;
    end

    assign walk_ext     = next_walk(stim_ext);
    assign lfsr_adv     = lfsr_step(lfsr_q);
    // The ramp ends on the all-ones vector.
    assign walk_last    = &stim_q;
    assign rand_last    = (rand_cnt == RAND_LAST);
    // The final random compare leaves the LFSR alone so stim can hold it in DONE.
    assign lfsr_step_en = cmp && (state == RAND) && !rand_last;
    assign unused_bits  = ^{walk_ext, lfsr_adv, lfsr_q, stim_ext};

    equiv_lfsr #(
        .RESET_VAL (SEED_EFF)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (start_acc),
        .seed  (SEED_EFF),
        .step  (lfsr_step_en),
        .q     (lfsr_q)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start) state_nxt = WALK;
            end
            WALK: begin
                if (cmp && walk_last) state_nxt = HAS_RAND ? RAND : DONE;
            end
            RAND: begin
                if (cmp && rand_last) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: stimulus, settle timer and run counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stim_q     <= '0;
            settle_cnt <= '0;
            vec_q      <= '0;
            mm_q       <= '0;
            rand_cnt   <= '0;
        end else if (start_acc) begin
            stim_q     <= '0;
            settle_cnt <= '0;
            vec_q      <= '0;
            mm_q       <= '0;
            rand_cnt   <= '0;
        end else if (running) begin
            if (cmp) begin
                settle_cnt <= '0;
                vec_q      <= vec_q + 1'b1;
                if (differ && (mm_q != '1)) mm_q <= mm_q + 1'b1;
                if (state == WALK) begin
                    if (!walk_last)    stim_q <= walk_ext[WIDTH-1:0];
                    else if (HAS_RAND) stim_q <= lfsr_q[WIDTH-1:0];
                end else begin
                    rand_cnt <= rand_cnt + 1'b1;
                    if (!rand_last) stim_q <= lfsr_adv[WIDTH-1:0];
                end
            end else begin
                settle_cnt <= settle_cnt + 1'b1;
            end
        end
    end

`ifdef EQUIV_FAIL_CAPTURE_EN
    // First-failure capture: armed by start, frozen after the first mismatch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_fail_vec    <= '0;
            first_fail_idx    <= '0;
            first_fail_golden <= '0;
            first_fail_valid  <= 1'b0;
        end else if (start_acc) begin
            first_fail_vec    <= '0;
            first_fail_idx    <= '0;
            first_fail_golden <= '0;
            first_fail_valid  <= 1'b0;
        end else if (cmp && differ && !first_fail_valid) begin
            first_fail_vec    <= stim_q;
            first_fail_idx    <= vec_q;
            first_fail_golden <= golden_b;
            first_fail_valid  <= 1'b1;
        end
    end
`endif

    assign stim         = stim_q;
    assign busy         = running;
    assign cmp_valid    = cmp;
    assign mismatch     = cmp && differ;
    assign mismatch_cnt = mm_q;
    assign vec_cnt      = vec_q;
    assign done         = (state == DONE);
    assign pass         = (state == DONE) && (mm_q == '0);

endmodule

// File: tb/tb_equiv_check_sequencer.sv
// Self-checking bench for equiv_check_sequencer: golden = &stim, netlist output
// perturbed per scenario (flip table keyed by stimulus, forced 1, or X on one vector).
// Expected sequences come from a list built straight from the ramp/LFSR rules.
module tb_equiv_check_sequencer;

    localparam int          TB_W      = 8;
    localparam int          TB_RAND   = 12;
    localparam int          TB_SETTLE = 3;
    localparam logic [31:0] TB_SEED   = 32'hACE1_1234;
    localparam int          N         = TB_W + 1 + TB_RAND;
    localparam int          BUDGET    = N * (TB_SETTLE + 1) + 40;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic            golden_b;
    logic            netlist_b;
    logic [TB_W-1:0] stim;
    logic            busy;
    logic            cmp_valid;
    logic            mismatch;
    logic [15:0]     mismatch_cnt;
    logic [15:0]     vec_cnt;
    logic            done;
    logic            pass;
`ifdef EQUIV_FAIL_CAPTURE_EN
    logic [TB_W-1:0] first_fail_vec;
    logic [15:0]     first_fail_idx;
    logic [0:0]      first_fail_golden;
    logic            first_fail_valid;
`endif

    // netlist perturbation controls
    logic [255:0]    flip_tab  = '0;
    logic            force_one = 1'b0;
    logic            x_en      = 1'b0;
    logic [TB_W-1:0] x_vec     = '0;

    int n_cmp  = 0;
    int n_fail = 0;

    // expected stimulus list and captured observations
    logic [TB_W-1:0] exp_vec[$];
    logic [TB_W-1:0] cap_vec[$];
    logic [TB_W-1:0] cap_win[$];
    bit              cap_mm[$];
    bit              cap_xmm[$];
    int              cap_cyc[$];
    bit              cap_timeout;

    always #5 clk = ~clk;

    always_comb begin
        golden_b  = &stim;
        netlist_b = golden_b ^ flip_tab[stim];
        if (force_one) netlist_b = 1'b1;
        if (x_en && (stim == x_vec)) netlist_b = 1'bx;
    end

    equiv_check_sequencer #(
        .WIDTH      (TB_W),
        .RAND_COUNT (TB_RAND),
        .SETTLE     (TB_SETTLE),
        .LFSR_SEED  (TB_SEED)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .golden_b          (golden_b),
        .netlist_b         (netlist_b),
        .stim              (stim),
        .busy              (busy),
        .cmp_valid         (cmp_valid),
        .mismatch          (mismatch),
        .mismatch_cnt      (mismatch_cnt),
        .vec_cnt           (vec_cnt),
        .done              (done),
`ifdef EQUIV_FAIL_CAPTURE_EN
        .first_fail_vec    (first_fail_vec),
        .first_fail_idx    (first_fail_idx),
        .first_fail_golden (first_fail_golden),
        .first_fail_valid  (first_fail_valid),
`endif
        .pass              (pass)
    );

    // Reference: ramp 0, 1, 3 ... all-ones, then seed and successive Galois steps.
    function automatic logic [31:0] galois(input logic [31:0] x);
        logic [31:0] y;
        y = x >> 1;
        if (x[0]) y = y ^ 32'h8020_0003;
        return y;
    endfunction

    function automatic void build_expect();
        logic [31:0] l;
        longint      ramp;
        exp_vec.delete();
        for (int k = 0; k <= TB_W; k++) begin
            ramp = (longint'(1) << k) - 1;
            exp_vec.push_back(ramp[TB_W-1:0]);
        end
        l = (TB_SEED == 0) ? 32'd1 : TB_SEED;
        for (int r = 0; r < TB_RAND; r++) begin
            exp_vec.push_back(l[TB_W-1:0]);
            l = galois(l);
        end
    endfunction

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Observes from the first vector cycle; stops on done, after stop_after
    // compares (0 = no limit), or when the cycle budget expires.
    task automatic run_capture(input int stop_after);
        int cyc;
        cap_vec.delete(); cap_win.delete(); cap_mm.delete();
        cap_xmm.delete(); cap_cyc.delete();
        cap_timeout = 1'b0;
        cyc = 0;
        forever begin
            if (cyc % (TB_SETTLE + 1) == 0) cap_win.push_back(stim);
            if (cmp_valid) begin
                cap_vec.push_back(stim);
                cap_mm.push_back(mismatch);
                cap_xmm.push_back(golden_b !== netlist_b);
                cap_cyc.push_back(cyc);
                if (stop_after > 0 && cap_vec.size() == stop_after) break;
            end
            if (done) break;
            if (cyc > BUDGET) begin
                cap_timeout = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if (stim !== '0 || busy !== 1'b0 || cmp_valid !== 1'b0 || mismatch !== 1'b0 ||
            done !== 1'b0 || pass !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got stim=%h busy=%b cmp=%b mm=%b done=%b pass=%b, want all 0",
                     stim, busy, cmp_valid, mismatch, done, pass);
        end
        n_cmp++;
        if (vec_cnt !== 16'd0 || mismatch_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_counters: got vec=%0d mm=%0d, want 0/0", vec_cnt, mismatch_cnt);
        end
    endtask

    task automatic test_match_run();
        flip_tab = '0;
        do_start();
        run_capture(0);
        n_cmp++;
        if (cap_timeout || cap_vec.size() != N) begin
            n_fail++;
            $display("FAIL match_len: got %0d compares (timeout=%b), want %0d", cap_vec.size(), cap_timeout, N);
        end
        for (int i = 0; i < cap_vec.size() && i < N; i++) begin
            n_cmp++;
            if (cap_vec[i] !== exp_vec[i] || cap_mm[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL match_vec[%0d]: got stim=%h mm=%b, want %h/0", i, cap_vec[i], cap_mm[i], exp_vec[i]);
            end
            n_cmp++;
            if (cap_cyc[i] != i * (TB_SETTLE + 1) + TB_SETTLE) begin
                n_fail++;
                $display("FAIL match_timing[%0d]: got cycle %0d, want %0d", i, cap_cyc[i], i * (TB_SETTLE + 1) + TB_SETTLE);
            end
            if (i < cap_win.size()) begin
                n_cmp++;
                if (cap_win[i] !== exp_vec[i]) begin
                    n_fail++;
                    $display("FAIL match_present[%0d]: got %h at window start, want %h", i, cap_win[i], exp_vec[i]);
                end
            end
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1 || pass !== 1'b1 || busy !== 1'b0 || vec_cnt !== 16'(N) ||
            mismatch_cnt !== 16'd0 || stim !== exp_vec[N-1]) begin
            n_fail++;
            $display("FAIL match_final: got done=%b pass=%b busy=%b vec=%0d mm=%0d stim=%h, want 1/1/0/%0d/0/%h",
                     done, pass, busy, vec_cnt, mismatch_cnt, stim, N, exp_vec[N-1]);
        end
    endtask

    task automatic test_restart_in_done();
        do_start();
        n_cmp++;
        if (vec_cnt !== 16'd0 || busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_clear: got vec=%0d busy=%b done=%b, want 0/1/0", vec_cnt, busy, done);
        end
        run_capture(0);
        n_cmp++;
        if (cap_timeout || cap_vec.size() != N) begin
            n_fail++;
            $display("FAIL restart_len: got %0d compares, want %0d", cap_vec.size(), N);
        end
        for (int i = 0; i < cap_vec.size() && i < N; i++) begin
            n_cmp++;
            if (cap_vec[i] !== exp_vec[i]) begin
                n_fail++;
                $display("FAIL restart_vec[%0d]: got %h, want %h", i, cap_vec[i], exp_vec[i]);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (vec_cnt !== 16'(N) || pass !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_final: got vec=%0d pass=%b, want %0d/1", vec_cnt, pass, N);
        end
    endtask

    task automatic test_force_one();
        int exp_cnt;
        force_one = 1'b1;
        do_start();
        run_capture(0);
        exp_cnt = 0;
        for (int i = 0; i < cap_vec.size() && i < N; i++) begin
            n_cmp++;
            if (cap_mm[i] !== (exp_vec[i] != '1)) begin
                n_fail++;
                $display("FAIL force1_mm[%0d]: got %b for stim %h, want %b", i, cap_mm[i], exp_vec[i], exp_vec[i] != '1);
            end
        end
        foreach (exp_vec[i]) if (exp_vec[i] != '1) exp_cnt++;
        @(negedge clk);
        n_cmp++;
        if (mismatch_cnt !== 16'(exp_cnt) || pass !== 1'b0 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL force1_final: got mm_cnt=%0d pass=%b done=%b, want %0d/0/1", mismatch_cnt, pass, done, exp_cnt);
        end
`ifdef EQUIV_FAIL_CAPTURE_EN
        n_cmp++;
        if (first_fail_valid !== 1'b1 || first_fail_vec !== '0 || first_fail_idx !== 16'd0 ||
            first_fail_golden !== 1'b0) begin
            n_fail++;
            $display("FAIL force1_capture: got valid=%b vec=%h idx=%0d gold=%b, want 1/00/0/0",
                     first_fail_valid, first_fail_vec, first_fail_idx, first_fail_golden);
        end
`endif
        force_one = 1'b0;
    endtask

    task automatic test_random_flips();
        int exp_cnt;
        int first;
        for (int w = 0; w < 8; w++) flip_tab[w*32 +: 32] = $urandom;
        do_start();
        run_capture(0);
        exp_cnt = 0;
        first = -1;
        foreach (exp_vec[i]) begin
            if (flip_tab[exp_vec[i]]) begin
                exp_cnt++;
                if (first < 0) first = i;
            end
        end
        for (int i = 0; i < cap_vec.size() && i < N; i++) begin
            n_cmp++;
            if (cap_mm[i] !== flip_tab[exp_vec[i]]) begin
                n_fail++;
                $display("FAIL flip_mm[%0d]: got %b for stim %h, want %b", i, cap_mm[i], exp_vec[i], flip_tab[exp_vec[i]]);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (mismatch_cnt !== 16'(exp_cnt) || pass !== (exp_cnt == 0)) begin
            n_fail++;
            $display("FAIL flip_final: got mm_cnt=%0d pass=%b, want %0d/%b", mismatch_cnt, pass, exp_cnt, exp_cnt == 0);
        end
`ifdef EQUIV_FAIL_CAPTURE_EN
        if (first >= 0) begin
            n_cmp++;
            if (first_fail_valid !== 1'b1 || first_fail_vec !== exp_vec[first] ||
                first_fail_idx !== 16'(first) || first_fail_golden !== (&exp_vec[first])) begin
                n_fail++;
                $display("FAIL flip_capture: got valid=%b vec=%h idx=%0d gold=%b, want 1/%h/%0d/%b",
                         first_fail_valid, first_fail_vec, first_fail_idx, first_fail_golden,
                         exp_vec[first], first, &exp_vec[first]);
            end
        end
`endif
        flip_tab = '0;
    endtask

    task automatic test_start_ignored();
        int k;
        int waited;
        k = $urandom_range(3, 10);
        do_start();
        run_capture(k);
        // now in the k-th compare cycle; a restart here must be ignored
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (vec_cnt !== 16'(k) || busy !== 1'b1 || stim !== exp_vec[k]) begin
            n_fail++;
            $display("FAIL start_ignored: got vec=%0d busy=%b stim=%h, want %0d/1/%h", vec_cnt, busy, stim, k, exp_vec[k]);
        end
        waited = 0;
        while (done !== 1'b1 && waited < BUDGET) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++;
        if (done !== 1'b1 || vec_cnt !== 16'(N) || mismatch_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL start_ignored_final: got done=%b vec=%0d mm=%0d, want 1/%0d/0", done, vec_cnt, mismatch_cnt, N);
        end
    endtask

    task automatic test_reset_mid_rand();
        do_start();
        run_capture(11);
        @(negedge clk);
        n_cmp++;
        if (vec_cnt !== 16'd11 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrand_pre: got vec=%0d busy=%b, want 11/1", vec_cnt, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (stim !== '0 || busy !== 1'b0 || vec_cnt !== 16'd0 || mismatch_cnt !== 16'd0 ||
            done !== 1'b0 || cmp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrand_reset: got stim=%h busy=%b vec=%0d mm=%0d done=%b cmp=%b, want all 0",
                     stim, busy, vec_cnt, mismatch_cnt, done, cmp_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_start();
        run_capture(0);
        n_cmp++;
        if (cap_timeout || cap_vec.size() != N) begin
            n_fail++;
            $display("FAIL midrand_len: got %0d compares, want %0d", cap_vec.size(), N);
        end
        for (int i = 0; i < cap_vec.size() && i < N; i++) begin
            n_cmp++;
            if (cap_vec[i] !== exp_vec[i]) begin
                n_fail++;
                $display("FAIL midrand_vec[%0d]: got %h, want %h", i, cap_vec[i], exp_vec[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_x_compare();
        int idx;
        int exp_cnt;
        idx   = $urandom_range(TB_W + 1, N - 1);
        x_vec = exp_vec[idx];
        x_en  = 1'b1;
        do_start();
        run_capture(0);
        exp_cnt = 0;
        for (int i = 0; i < cap_vec.size() && i < N; i++) begin
            if (cap_xmm[i]) exp_cnt++;
            n_cmp++;
            if (cap_mm[i] !== cap_xmm[i]) begin
                n_fail++;
                $display("FAIL xcmp_mm[%0d]: got %b for stim %h, want %b", i, cap_mm[i], cap_vec[i], cap_xmm[i]);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (mismatch_cnt !== 16'(exp_cnt) || pass !== (exp_cnt == 0)) begin
            n_fail++;
            $display("FAIL xcmp_final: got mm_cnt=%0d pass=%b, want %0d/%b", mismatch_cnt, pass, exp_cnt, exp_cnt == 0);
        end
        x_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        build_expect();
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_match_run();
        test_restart_in_done();
        test_force_one();
        test_random_flips();
        test_start_ignored();
        test_reset_mid_rand();
        test_x_compare();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/equiv_check_sequencer.md
Name: equiv_check_sequencer

Overview:
- Hardware stimulus sequencer and self-checker for gate-level equivalence runs of small combinational testcases (8-input AND class).
- Drives one shared stimulus bus into a golden instance and a post-route netlist instance, then waits a settle window.
- Compares the two outputs and tallies mismatches.
- Sequence is a walking-ones ramp followed by a configurable count of pseudo-random vectors; a pass/fail verdict is reported at completion.

Parameters:
- WIDTH, 8: stimulus width in bits (legal range 1..32).
- RAND_COUNT, 3000: number of random vectors after the ramp (legal range 0..65535).
- SETTLE, 1: cycles between driving a vector and its compare (legal range 1..255).
- LFSR_SEED, 32'h0000_0001: LFSR initial value; a seed of 0 is replaced by 1.

Ports:
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE.
- golden_b  in  1  golden model output.
- netlist_b  in  1  post-route netlist output.
- stim  out  WIDTH  shared stimulus to both instances.
- busy  out  1  high from the start-accept cycle through the last compare.
- cmp_valid  out  1  one-cycle pulse on each compare cycle.
- mismatch  out  1  valid with cmp_valid; 1 = outputs differed.
- mismatch_cnt  out  16  saturating mismatch count.
- vec_cnt  out  16  vectors compared in the current run.
- done  out  1  high in DONE until the next start.
- pass  out  1  done && mismatch_cnt==0.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE.
  - stim=0, busy=0, cmp_valid=0, mismatch=0, done=0, pass=0.
  - Both counters 0; LFSR loaded with seed.
- States: IDLE -> WALK -> RAND -> DONE.
  - DONE -> WALK on start.
  - start while busy is ignored.
- Start accept cycle: counters cleared, LFSR reseeded, stim=0, busy=1, state WALK, settle counter=0.
- Per-vector timing:
  - Vector presented at cycle t.
  - Compare at t+SETTLE: cmp_valid=1, mismatch=(golden_b !== netlist_b), vec_cnt++, mismatch_cnt++ if mismatch (saturates at 16'hFFFF).
  - Next vector presented at t+SETTLE+1, so each vector takes SETTLE+1 cycles.
- WALK: WIDTH+1 vectors: 0, then stim = {stim[WIDTH-2:0],1'b1} after each compare (0x00, 0x01, 0x03 ... 0xFF). After the compare of the all-ones vector:
  - If RAND_COUNT==0: go to DONE.
  - Otherwise: go to RAND with stim = lfsr[WIDTH-1:0].
- RAND:
  - LFSR is 32-bit Galois, polynomial constant 32'h8020_0003; it advances once per compare.
  - stim takes the advanced value's low WIDTH bits.
  - After RAND_COUNT compares, go to DONE.
- DONE: busy=0, done=1, pass valid, stim holds the last vector, counters hold their values.
- Total compares per run = WIDTH+1+RAND_COUNT; vec_cnt wraps modulo 2^16 (documented limitation).
- Async reset mid-run aborts immediately to reset values; no partial verdict is retained.
- Compare is 4-state in simulation: X/Z on either output counts as a mismatch. Synthesis reduces it to !=.

Optional Feature:
- Macro: EQUIV_FAIL_CAPTURE_EN
- Defined:
  - Adds outputs first_fail_vec[WIDTH-1:0], first_fail_idx[15:0], first_fail_golden[0:0] and first_fail_valid.
  - These latch on the first mismatching compare of a run.
  - They are cleared by reset or start and are never overwritten within a run.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package equiv_check_pkg holds:
  - state_t enum {IDLE, WALK, RAND, DONE}.
  - LFSR_POLY = 32'h8020_0003.
  - CNT_W = 16.
  - Function next_walk(stim).
- One sub-module, equiv_lfsr: Galois LFSR with ports clk, rst_n, load, seed, step, q[31:0].

Test Plan:
- Matching models (golden = netlist = &stim), RAND_COUNT=4, SETTLE=1 -> stim sequence 0x00, 0x01, 0x03 ... 0xFF, then 4 LFSR values. 13 cmp_valid pulses, one every 2 cycles. done=1, pass=1, vec_cnt=13, mismatch_cnt=0.
- netlist_b forced to 1 throughout, RAND_COUNT=0 -> the 8 walk vectors 0x00..0x7F mismatch, 0xFF matches. mismatch_cnt=8, pass=0. With EQUIV_FAIL_CAPTURE_EN: first_fail_vec=0x00, first_fail_idx=0.
- SETTLE=3 -> each compare occurs exactly 3 cycles after its stim change; cmp_valid spacing is 4 cycles.
- rst_n asserted mid-RAND (vec_cnt=11) -> same cycle: stim=0, busy=0, counters 0. A following start produces a stimulus sequence identical to the first run.
- start pulsed during busy -> ignored, vec_cnt continues unchanged. start in DONE -> counters clear and the run repeats with the same LFSR sequence.
- netlist_b driven X on one random vector -> that compare shows mismatch=1 and mismatch_cnt=1.
